// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencing controller: opcodes, flag
// positions, instruction field layout and FSM encoding.
package alu_ctrl_pkg;

  localparam int unsigned DataW   = 16;
  localparam int unsigned NumRegs = 8;
  localparam int unsigned AddrW   = 3;
  localparam int unsigned FlgW    = 5;

  // External ALU operation codes
  typedef enum logic [2:0] {
    OpAdd   = 3'b000,
    OpSub   = 3'b001,
    OpAnd   = 3'b010,
    OpOr    = 3'b011,
    OpXor   = 3'b100,
    OpNot   = 3'b101,
    OpPass1 = 3'b110,
    OpPass2 = 3'b111
  } alu_op_e;

  // Flag bit positions, flag vector is {Z,CY,S,P,OV}
  localparam int unsigned FlgZ  = 4;
  localparam int unsigned FlgCy = 3;
  localparam int unsigned FlgS  = 2;
  localparam int unsigned FlgP  = 1;
  localparam int unsigned FlgOv = 0;

  // Instruction field positions
  localparam int unsigned OpMsb   = 15;
  localparam int unsigned OpLsb   = 13;
  localparam int unsigned RdMsb   = 12;
  localparam int unsigned RdLsb   = 10;
  localparam int unsigned Rs1Msb  = 9;
  localparam int unsigned Rs1Lsb  = 7;
  localparam int unsigned Rs2Msb  = 6;
  localparam int unsigned Rs2Lsb  = 4;
  localparam int unsigned WideBit = 3;
  localparam int unsigned KeepBit = 2;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StExecLo = 2'b01,
    StExecHi = 2'b10,
    StDone   = 2'b11
  } state_e;

  // Low (even) register of the pair containing addr
  function automatic logic [AddrW-1:0] pair_lo(input logic [AddrW-1:0] addr);
    return {addr[AddrW-1:1], 1'b0};
  endfunction

  // High (odd) register of the pair containing addr
  function automatic logic [AddrW-1:0] pair_hi(input logic [AddrW-1:0] addr);
    return {addr[AddrW-1:1], 1'b1};
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 8x16 register file: two combinational read ports, one execution write
// port and one external load port, synchronously cleared.
module regfile8x16
  import alu_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [AddrW-1:0] i_raddr1,
  output logic [DataW-1:0] o_rdata1,
  input  logic [AddrW-1:0] i_raddr2,
  output logic [DataW-1:0] o_rdata2,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [DataW-1:0] i_wdata,
  input  logic             i_ld_we,
  input  logic [AddrW-1:0] i_ld_addr,
  input  logic [DataW-1:0] i_ld_data
);

  logic [DataW-1:0] r_mem [NumRegs];

  // Storage update; reset wins so an aborted op never leaves a partial write
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_we) begin
        r_mem[i_waddr] <= i_wdata;
      end
      // The controller never raises both together; load is ordered last anyway
      if (i_ld_we) begin
        r_mem[i_ld_addr] <= i_ld_data;
      end
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/alu_ctrl.sv
// Sequencer for an external 16-bit ALU: accepts instructions, reads operands
// from the register file, writes results back and maintains the flag
// register. Wide ops run as two chained 16-bit steps on register pairs.
module alu_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_instr_valid,
  input  logic [15:0]      i_instr,
  output logic             o_instr_ready,
  input  logic             i_ld_valid,
  input  logic [AddrW-1:0] i_ld_addr,
  input  logic [DataW-1:0] i_ld_data,
  output logic [2:0]       o_alu_opcode,
  output logic [DataW-1:0] o_alu_arg1,
  output logic [DataW-1:0] o_alu_arg2,
  output logic [FlgW-1:0]  o_alu_in_flg,
  output logic             o_alu_block,
  input  logic [DataW-1:0] i_alu_res,
  input  logic [FlgW-1:0]  i_alu_out_flg,
  output logic [FlgW-1:0]  o_flags,
  output logic             o_done,
  output logic             o_busy
);

  state_e           r_state;
  state_e           w_state_next;

  logic [2:0]       r_op;
  logic [AddrW-1:0] r_rd;
  logic [AddrW-1:0] r_rs1;
  logic [AddrW-1:0] r_rs2;
  logic             r_wide;
  logic             r_keep;
  logic             r_lo_z;
  logic             r_lo_cy;
  logic [FlgW-1:0]  r_flags;

  logic             w_accept;
  logic             w_ld_we;
  logic             w_we;
  logic [AddrW-1:0] w_raddr1;
  logic [AddrW-1:0] w_raddr2;
  logic [AddrW-1:0] w_waddr;
  logic [DataW-1:0] w_rdata1;
  logic [DataW-1:0] w_rdata2;
  logic [FlgW-1:0]  w_hi_flags;
  logic             w_unused_instr;

  assign w_accept       = i_instr_valid && (r_state == StIdle);
  assign w_ld_we        = i_ld_valid && (r_state == StIdle);
  assign w_unused_instr = ^i_instr[1:0];

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (w_accept) w_state_next = StExecLo;
      StExecLo: w_state_next = r_wide ? StExecHi : StDone;
      StExecHi: w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Latch the accepted instruction fields
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op   <= '0;
      r_rd   <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_wide <= 1'b0;
      r_keep <= 1'b0;
    end else if (w_accept) begin
      r_op   <= i_instr[OpMsb:OpLsb];
      r_rd   <= i_instr[RdMsb:RdLsb];
      r_rs1  <= i_instr[Rs1Msb:Rs1Lsb];
      r_rs2  <= i_instr[Rs2Msb:Rs2Lsb];
      r_wide <= i_instr[WideBit];
      r_keep <= i_instr[KeepBit];
    end
  end

  // Register-file addressing: pair halves for wide steps, raw fields otherwise.
  // Low step writes an even register and high step reads odd ones, so the
  // high operands are always the pre-instruction values.
  always_comb begin
    w_raddr1 = r_rs1;
    w_raddr2 = r_rs2;
    w_waddr  = r_rd;
    w_we     = 1'b0;
    case (r_state)
      StExecLo: begin
        w_we = 1'b1;
        if (r_wide) begin
          w_raddr1 = pair_lo(r_rs1);
          w_raddr2 = pair_lo(r_rs2);
          w_waddr  = pair_lo(r_rd);
        end
      end
      StExecHi: begin
        w_we     = 1'b1;
        w_raddr1 = pair_hi(r_rs1);
        w_raddr2 = pair_hi(r_rs2);
        w_waddr  = pair_hi(r_rd);
      end
      default: ;
    endcase
  end

  // Combined flags for the end of a wide op
  always_comb begin
    w_hi_flags        = i_alu_out_flg;
    w_hi_flags[FlgZ]  = r_lo_z & i_alu_out_flg[FlgZ];
    w_hi_flags[FlgCy] = r_lo_cy;
  end

  // Flag register and the low-half zero/carry carried into the high step
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_flags <= '0;
      r_lo_z  <= 1'b0;
      r_lo_cy <= 1'b0;
    end else begin
      case (r_state)
        StExecLo: begin
          if (r_wide) begin
            r_lo_z  <= i_alu_out_flg[FlgZ];
            r_lo_cy <= i_alu_out_flg[FlgCy];
          end else begin
            r_flags <= i_alu_out_flg;
          end
        end
        StExecHi: r_flags <= w_hi_flags;
        default: ;
      endcase
    end
  end

  // FSM outputs and ALU drive; idle pattern is PASS2 of zero with block set
  always_comb begin
    o_instr_ready = (r_state == StIdle);
    o_busy        = (r_state != StIdle);
    o_done        = (r_state == StDone);
    o_flags       = r_flags;
    o_alu_opcode  = OpPass2;
    o_alu_arg1    = '0;
    o_alu_arg2    = '0;
    o_alu_block   = 1'b1;
    o_alu_in_flg  = r_flags;
    case (r_state)
      StExecLo: begin
        o_alu_opcode = r_op;
        o_alu_arg1   = w_rdata1;
        o_alu_arg2   = w_rdata2;
        o_alu_block  = r_wide ? 1'b0 : r_keep;
      end
      StExecHi: begin
        o_alu_opcode        = r_op;
        o_alu_arg1          = w_rdata1;
        o_alu_arg2          = w_rdata2;
        o_alu_block         = 1'b1;
        o_alu_in_flg[FlgCy] = r_lo_cy;
      end
      default: ;
    endcase
  end

  regfile8x16 u_regfile (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_raddr1  (w_raddr1),
    .o_rdata1  (w_rdata1),
    .i_raddr2  (w_raddr2),
    .o_rdata2  (w_rdata2),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (i_alu_res),
    .i_ld_we   (w_ld_we),
    .i_ld_addr (i_ld_addr),
    .i_ld_data (i_ld_data)
  );

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU attached to the ALU port, directed
// scenarios followed by random instructions checked against a register-level
// model that treats wide ops as plain 32-bit arithmetic.
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_arg1;
  logic [15:0] alu_arg2;
  logic [4:0]  alu_in_flg;
  logic        alu_block;
  logic [15:0] alu_res;
  logic [4:0]  alu_out_flg;
  logic [4:0]  flags;
  logic        done;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_reg [8];
  logic [4:0]  m_flags;

  always #5 clk = ~clk;

  // Behavioural ALU: block=1 adds carry-in and passes CY/OV through
  function automatic logic [20:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [4:0] fi,
                                        input logic blk);
    logic [16:0] t;
    logic [15:0] r;
    logic        cy;
    logic        ov;
    logic        cin;
    cin = blk ? fi[FlgCy] : 1'b0;
    cy  = 1'b0;
    ov  = 1'b0;
    t   = '0;
    case (op)
      OpAdd: begin
        t  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        r  = t[15:0];
        cy = t[16];
        ov = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OpSub: begin
        t  = {1'b0, a} - {1'b0, b} - {16'd0, cin};
        r  = t[15:0];
        cy = t[16];
        ov = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      OpNot:   r = ~a;
      OpPass1: r = a;
      default: r = b;
    endcase
    if (blk) begin
      cy = fi[FlgCy];
      ov = fi[FlgOv];
    end
    return {(r == 16'd0), cy, r[15], ^r, ov, r};
  endfunction

  assign {alu_out_flg, alu_res} = alu_f(alu_opcode, alu_arg1, alu_arg2, alu_in_flg, alu_block);

  alu_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_instr_valid (instr_valid),
    .i_instr       (instr),
    .o_instr_ready (instr_ready),
    .i_ld_valid    (ld_valid),
    .i_ld_addr     (ld_addr),
    .i_ld_data     (ld_data),
    .o_alu_opcode  (alu_opcode),
    .o_alu_arg1    (alu_arg1),
    .o_alu_arg2    (alu_arg2),
    .o_alu_in_flg  (alu_in_flg),
    .o_alu_block   (alu_block),
    .i_alu_res     (alu_res),
    .i_alu_out_flg (alu_out_flg),
    .o_flags       (flags),
    .o_done        (done),
    .o_busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic w, input logic k);
    return {op, rd, rs1, rs2, w, k, 2'b00};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_flags = '0;
  endtask

  // Architectural effect of one instruction
  task automatic m_exec(input logic [15:0] ins);
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [20:0] o;
    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] r32;
    logic [16:0] lsum;
    logic        lcy;
    op  = ins[15:13];
    rd  = ins[12:10];
    rs1 = ins[9:7];
    rs2 = ins[6:4];
    if (!ins[3]) begin
      o         = alu_f(op, m_reg[rs1], m_reg[rs2], m_flags, ins[2]);
      m_reg[rd] = o[15:0];
      m_flags   = o[20:16];
    end else begin
      a32  = {m_reg[{rs1[2:1], 1'b1}], m_reg[{rs1[2:1], 1'b0}]};
      b32  = {m_reg[{rs2[2:1], 1'b1}], m_reg[{rs2[2:1], 1'b0}]};
      lcy  = 1'b0;
      lsum = {1'b0, a32[15:0]} + {1'b0, b32[15:0]};
      case (op)
        OpAdd: begin r32 = a32 + b32; lcy = lsum[16]; end
        OpSub: begin r32 = a32 - b32; lcy = (a32[15:0] < b32[15:0]); end
        OpAnd:   r32 = a32 & b32;
        OpOr:    r32 = a32 | b32;
        OpXor:   r32 = a32 ^ b32;
        OpNot:   r32 = ~a32;
        OpPass1: r32 = a32;
        default: r32 = b32;
      endcase
      m_reg[{rd[2:1], 1'b0}] = r32[15:0];
      m_reg[{rd[2:1], 1'b1}] = r32[31:16];
      m_flags = {(r32 == 32'd0), lcy, r32[31], ^r32[31:16], m_flags[FlgOv]};
    end
  endtask

  task automatic cmp_state(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_r%0d", tag, i), {16'd0, dut.u_regfile.r_mem[i]}, {16'd0, m_reg[i]});
    end
    check({tag, "_flags"}, {27'd0, flags}, {27'd0, m_flags});
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    m_reg[a] = d;
  endtask

  // Issue one instruction from IDLE and follow it to completion. hold keeps
  // instr_valid high and pokes the load port while busy.
  task automatic issue(input logic [15:0] ins, input bit hold, input bit ld_same,
                       input logic [2:0] la, input logic [15:0] ld);
    int lat;
    check("ready_idle", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr       = ins;
    if (ld_same) begin
      ld_valid = 1'b1;
      ld_addr  = la;
      ld_data  = ld;
    end
    @(posedge clk); #1;
    if (ld_same) m_reg[la] = ld;
    ld_valid = 1'b0;
    if (!hold) instr_valid = 1'b0;
    m_exec(ins);
    lat = 1;
    while (!done && lat < 8) begin
      check("ready_busy", {31'd0, instr_ready}, 32'd0);
      check("busy_exec", {31'd0, busy}, 32'd1);
      if (hold) begin
        ld_valid = 1'b1;
        ld_addr  = 3'($urandom);
        ld_data  = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    ld_valid = 1'b0;
    check("latency", lat, ins[3] ? 32'd3 : 32'd2);
    check("done_busy", {31'd0, busy}, 32'd1);
    check("done_opc", {29'd0, alu_opcode}, 32'd7);
    check("done_args", {alu_arg1, alu_arg2}, 32'd0);
    check("done_blk", {31'd0, alu_block}, 32'd1);
    check("done_inflg", {27'd0, alu_in_flg}, {27'd0, m_flags});
    cmp_state("post");
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done}, 32'd0);
    check("back_idle", {31'd0, instr_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] ins;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    ld_valid    = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_opc", {29'd0, alu_opcode}, 32'd7);
    check("rst_args", {alu_arg1, alu_arg2}, 32'd0);
    check("rst_blk", {31'd0, alu_block}, 32'd1);
    check("rst_inflg", {27'd0, alu_in_flg}, 32'd0);
    cmp_state("rst");

    // Narrow ADD with signed overflow
    load(3'd1, 16'h7FFF);
    load(3'd2, 16'h0001);
    issue(mk(OpAdd, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0), 1'b0, 1'b0, 3'd0, 16'd0);
    check("add_r3", {16'd0, dut.u_regfile.r_mem[3]}, 32'h8000);
    check("add_flags", {27'd0, flags}, 32'b00111);

    // Wide ADD with carry from the low half
    load(3'd0, 16'hFFFF);
    load(3'd1, 16'h0000);
    load(3'd2, 16'h0001);
    load(3'd3, 16'h0000);
    issue(mk(OpAdd, 3'd4, 3'd0, 3'd2, 1'b1, 1'b0), 1'b0, 1'b0, 3'd0, 16'd0);
    check("wadd_r4", {16'd0, dut.u_regfile.r_mem[4]}, 32'h0000);
    check("wadd_r5", {16'd0, dut.u_regfile.r_mem[5]}, 32'h0001);
    check("wadd_z", {31'd0, flags[FlgZ]}, 32'd0);
    check("wadd_cy", {31'd0, flags[FlgCy]}, 32'd1);

    // SUB with rd aliasing both sources
    load(3'd5, 16'h1234);
    issue(mk(OpSub, 3'd5, 3'd5, 3'd5, 1'b0, 1'b0), 1'b0, 1'b0, 3'd0, 16'd0);
    check("sub_r5", {16'd0, dut.u_regfile.r_mem[5]}, 32'h0000);
    check("sub_z", {31'd0, flags[FlgZ]}, 32'd1);
    check("sub_cy", {31'd0, flags[FlgCy]}, 32'd0);

    // Keep: carry-in used, CY/OV preserved
    load(3'd6, 16'hFFFF);
    load(3'd7, 16'h0001);
    issue(mk(OpAdd, 3'd0, 3'd6, 3'd7, 1'b0, 1'b0), 1'b0, 1'b0, 3'd0, 16'd0);
    check("setcy_flags", {27'd0, flags}, 32'b11000);
    load(3'd1, 16'h0001);
    load(3'd2, 16'h0001);
    issue(mk(OpAdd, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1), 1'b0, 1'b0, 3'd0, 16'd0);
    check("keep_r3", {16'd0, dut.u_regfile.r_mem[3]}, 32'h0003);
    check("keep_flags", {27'd0, flags}, 32'b01000);

    // instr_valid held through busy, loads while busy ignored, back-to-back accept
    issue(mk(OpXor, 3'd2, 3'd1, 3'd6, 1'b0, 1'b0), 1'b1, 1'b0, 3'd0, 16'd0);
    issue(mk(OpOr, 3'd7, 3'd1, 3'd2, 1'b1, 1'b0), 1'b0, 1'b0, 3'd0, 16'd0);

    // Load and accept in the same cycle: instruction sees the loaded value
    issue(mk(OpAdd, 3'd0, 3'd4, 3'd4, 1'b0, 1'b0), 1'b0, 1'b1, 3'd4, 16'h0123);
    check("ldacc_r0", {16'd0, dut.u_regfile.r_mem[0]}, 32'h0246);

    // Reset during the high step of a wide op
    load(3'd2, 16'h1111);
    load(3'd3, 16'h2222);
    instr_valid = 1'b1;
    instr       = mk(OpAdd, 3'd6, 3'd2, 3'd2, 1'b1, 1'b0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("hi_blk", {31'd0, alu_block}, 32'd1);
    check("hi_arg1", {16'd0, alu_arg1}, 32'h2222);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check("abort_ready", {31'd0, instr_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_r7", {16'd0, dut.u_regfile.r_mem[7]}, 32'd0);
    cmp_state("abort");
    @(posedge clk); #1;
    check("abort_nodone", {31'd0, done}, 32'd0);

    // Random instructions against the model
    for (int i = 0; i < 8; i++) load(3'(i), 16'($urandom));
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 1) load(3'($urandom), 16'($urandom));
      ins = 16'($urandom);
      issue(ins, 1'b0, ($urandom_range(0, 3) == 0), 3'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
